// File: rtl/hs_sync_pkg.sv
// Shared types and constants for the four-phase handshake synchronizer.
package hs_sync_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam logic RST_VAL         = 1'b0;
  localparam int   MIN_SYNC_STAGES = 2;

  function automatic bit stages_ok(input int s);
    return s >= MIN_SYNC_STAGES;
  endfunction

endpackage

// File: rtl/hs_sync_chain.sv
// Enabled shift-register synchronizer chain with synchronous reset.
module hs_sync_chain
  import hs_sync_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic q,
  output logic tap
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst)     sr <= {DEPTH{RST_VAL}};
    else if (en) sr <= {sr[DEPTH-2:0], d};
  end

  assign q   = sr[DEPTH-1];
  // Second-to-last stage: lets the consumer see a rising edge one strobe early.
  assign tap = sr[DEPTH-2];

endmodule

// File: rtl/hs_sync.sv
// Four-phase req/ack event synchronizer: edge detect, handshake FSM, pulse output.
module hs_sync
  import hs_sync_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clkA,
  input  logic resetA,
  input  logic enB,
  input  logic inA,
  output logic outB_level,
  output logic outB_pulse,
  output logic busy
);

  if (!stages_ok(SYNC_STAGES)) begin : g_bad_stages
    $error("hs_sync: SYNC_STAGES must be >= %0d", MIN_SYNC_STAGES);
  end

  state_t state;
  logic   inA_d, req, ack_a, req_tap, ack_tap_unused;
  logic   rise;

  assign rise = inA & ~inA_d;

  hs_sync_chain #(.DEPTH(SYNC_STAGES)) u_req_chain (
    .clk (clkA),
    .rst (resetA),
    .en  (enB),
    .d   (req),
    .q   (outB_level),
    .tap (req_tap)
  );

  hs_sync_chain #(.DEPTH(SYNC_STAGES)) u_ack_chain (
    .clk (clkA),
    .rst (resetA),
    .en  (1'b1),
    .d   (outB_level),
    .q   (ack_a),
    .tap (ack_tap_unused)
  );

  // Rises arriving outside IDLE are dropped, not queued.
  always_ff @(posedge clkA) begin
    if (resetA) begin
      inA_d <= RST_VAL;
      state <= IDLE;
      req   <= RST_VAL;
      busy  <= RST_VAL;
    end else begin
      inA_d <= inA;
      case (state)
        IDLE: if (rise) begin
          state <= REQ;
          req   <= 1'b1;
          busy  <= 1'b1;
        end
        REQ: if (ack_a) begin
          state <= DROP;
          req   <= 1'b0;
        end
        DROP: if (!ack_a) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          req   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clkA) begin
    if (resetA) outB_pulse <= RST_VAL;
    else        outB_pulse <= enB & req_tap & ~outB_level;
  end

endmodule

// File: tb/tb_hs_sync.sv
// Directed bench for hs_sync: S=2 and S=3 instances share stimulus.
module tb_hs_sync;

  logic clk = 1'b0;
  logic resetA, enB, inA;
  logic lvl2, pul2, bsy2, lvl3, pul3, bsy3;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  hs_sync #(.SYNC_STAGES(2)) dut2 (
    .clkA(clk), .resetA(resetA), .enB(enB), .inA(inA),
    .outB_level(lvl2), .outB_pulse(pul2), .busy(bsy2)
  );

  hs_sync #(.SYNC_STAGES(3)) dut3 (
    .clkA(clk), .resetA(resetA), .enB(enB), .inA(inA),
    .outB_level(lvl3), .outB_pulse(pul3), .busy(bsy3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetA = 1'b1; inA = 1'b0; enB = 1'b1;
    tick(); tick();
    resetA = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] got;
    resetA = 1'b1; inA = 1'b1; enB = 1'b1;
    tick(); tick();
    got = {lvl2, pul2, bsy2, lvl3, pul3, bsy3};
    for (int i = 0; i < 6; i++) begin
      n_chk++;
      if (got[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_out[%0d]: got %b expected 0", i, got[i]);
      end
    end
    inA = 1'b0;
    tick();
    resetA = 1'b0;
  endtask

  task automatic test_single_pulse();
    int pc = 0, lc = 0, bc = 0, pf = -1, lf = -1, bf = -1;
    do_reset();
    inA = 1'b1;
    for (int c = 0; c < 16; c++) begin
      tick();
      inA = 1'b0;
      if (pul2) begin pc++; if (pf < 0) pf = c; end
      if (lvl2) begin lc++; if (lf < 0) lf = c; end
      if (bsy2) begin bc++; if (bf < 0) bf = c; end
    end
    n_chk++; if (pc !== 1)  begin n_fail++; $display("FAIL single_pulse_count: got %0d expected 1", pc); end
    n_chk++; if (pf !== 2)  begin n_fail++; $display("FAIL single_pulse_cycle: got %0d expected 2", pf); end
    n_chk++; if (lc !== 5)  begin n_fail++; $display("FAIL single_level_len: got %0d expected 5", lc); end
    n_chk++; if (lf !== 2)  begin n_fail++; $display("FAIL single_level_cycle: got %0d expected 2", lf); end
    n_chk++; if (bc !== 10) begin n_fail++; $display("FAIL single_busy_len: got %0d expected 10", bc); end
    n_chk++; if (bf !== 0)  begin n_fail++; $display("FAIL single_busy_cycle: got %0d expected 0", bf); end
  endtask

  task automatic test_long_high(input int len);
    int pc = 0, bc = 0;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      inA = (c < len);
      tick();
      if (pul2) pc++;
      if (bsy2) bc++;
    end
    inA = 1'b0;
    n_chk++; if (pc !== 1)  begin n_fail++; $display("FAIL long_high_%0d_pulses: got %0d expected 1", len, pc); end
    n_chk++; if (bc !== 10) begin n_fail++; $display("FAIL long_high_%0d_busy: got %0d expected 10", len, bc); end
  endtask

  task automatic test_back_to_back();
    int acc[4] = '{-1, -1, -1, -1};
    int exp_acc[4] = '{0, 12, 24, 36};
    int na = 0, pc = 0;
    logic bprev = 1'b0;
    do_reset();
    for (int c = 0; c < 50; c++) begin
      inA = (c < 40) && (c % 2 == 0);
      tick();
      if (bsy2 && !bprev) begin
        if (na < 4) acc[na] = c;
        na++;
      end
      bprev = bsy2;
      if (pul2) pc++;
    end
    inA = 1'b0;
    n_chk++; if (na !== 4) begin n_fail++; $display("FAIL b2b_accepts: got %0d expected 4", na); end
    n_chk++; if (pc !== 4) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 4", pc); end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (acc[i] !== exp_acc[i]) begin
        n_fail++;
        $display("FAIL b2b_accept_%0d: got cycle %0d expected %0d", i, acc[i], exp_acc[i]);
      end
    end
  endtask

  task automatic test_slow_enb();
    int pc = 0, lc = 0, bc = 0, pf = -1, lf = -1;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      inA = (c == 0);
      enB = (c % 3 == 1);
      tick();
      if (pul2) begin pc++; if (pf < 0) pf = c; end
      if (lvl2) begin lc++; if (lf < 0) lf = c; end
      if (bsy2) bc++;
    end
    enB = 1'b1;
    n_chk++; if (lf !== 4)  begin n_fail++; $display("FAIL slow_level_cycle: got %0d expected 4", lf); end
    n_chk++; if (pf !== 4)  begin n_fail++; $display("FAIL slow_pulse_cycle: got %0d expected 4", pf); end
    n_chk++; if (pc !== 1)  begin n_fail++; $display("FAIL slow_pulse_width: got %0d expected 1", pc); end
    n_chk++; if (lc !== 9)  begin n_fail++; $display("FAIL slow_level_len: got %0d expected 9", lc); end
    n_chk++; if (bc !== 16) begin n_fail++; $display("FAIL slow_busy_len: got %0d expected 16", bc); end
  endtask

  task automatic test_reset_mid();
    int pre_pc = 0, post = 0;
    do_reset();
    inA = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      inA = 1'b0;
      if (pul2) pre_pc++;
    end
    resetA = 1'b1;
    tick();
    n_chk++; if (pre_pc !== 1) begin n_fail++; $display("FAIL mid_pre_pulse: got %0d expected 1", pre_pc); end
    n_chk++;
    if ({lvl2, pul2, bsy2} !== 3'b000) begin
      n_fail++; $display("FAIL mid_reset_outs: got %b expected 000", {lvl2, pul2, bsy2});
    end
    resetA = 1'b0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (lvl2 || pul2 || bsy2) post++;
    end
    n_chk++; if (post !== 0) begin n_fail++; $display("FAIL mid_late_activity: got %0d cycles expected 0", post); end
    // inA held high through reset: first post-reset edge must accept.
    inA = 1'b1; resetA = 1'b1;
    tick(); tick();
    resetA = 1'b0;
    tick();
    n_chk++; if (bsy2 !== 1'b1) begin n_fail++; $display("FAIL mid_reaccept_busy: got %b expected 1", bsy2); end
    tick(); tick();
    n_chk++; if (pul2 !== 1'b1) begin n_fail++; $display("FAIL mid_reaccept_pulse: got %b expected 1", pul2); end
    inA = 1'b0;
  endtask

  task automatic test_sync3();
    int pc = 0, lc = 0, bc = 0, pf = -1, lf = -1;
    do_reset();
    inA = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      inA = 1'b0;
      if (pul3) begin pc++; if (pf < 0) pf = c; end
      if (lvl3) begin lc++; if (lf < 0) lf = c; end
      if (bsy3) bc++;
    end
    n_chk++; if (lf !== 3)  begin n_fail++; $display("FAIL s3_level_cycle: got %0d expected 3", lf); end
    n_chk++; if (pf !== 3)  begin n_fail++; $display("FAIL s3_pulse_cycle: got %0d expected 3", pf); end
    n_chk++; if (pc !== 1)  begin n_fail++; $display("FAIL s3_pulse_count: got %0d expected 1", pc); end
    n_chk++; if (lc !== 7)  begin n_fail++; $display("FAIL s3_level_len: got %0d expected 7", lc); end
    n_chk++; if (bc !== 14) begin n_fail++; $display("FAIL s3_busy_len: got %0d expected 14", bc); end
  endtask

  initial begin
    resetA = 1'b1; inA = 1'b0; enB = 1'b1;
    test_reset();
    test_single_pulse();
    test_long_high(7);
    test_long_high(20);
    test_back_to_back();
    test_slow_enb();
    test_reset_mid();
    test_sync3();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
